sev_seg_reader: RTL
===================

Name: sev_seg_reader

Overview:
- Receive-side counterpart of the seven-segment display driver.
- Samples a time-multiplexed 4-digit display bus: 7 segment lines plus 4 digit-enable lines.
- Decodes each stable segment pattern back to a hex nibble and assembles a 16-bit value.
- Used on the bench and in loopback designs to check what the display path actually drives.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (legal range 2..255)
SEG_ACTIVE_LOW, 0, 1 = seg_in and an_in are active-low; both are inverted internally before any other logic

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
seg_in  input  7  segment lines, bit0=a, bit1=b, ..., bit6=g (1 = lit when SEG_ACTIVE_LOW=0)
an_in  input  4  digit enables, one-hot; an_in[i] selects digit i
value  output  16  last completed frame; digit i in value[4i+3:4i]
frame_valid  output  1  one-cycle pulse when value/frame_err update
frame_err  output  1  1 if any digit of the last frame had an illegal pattern
digit_mask  output  4  digits captured so far in the current frame

Behaviour:
- Reset (rst=1 at an edge): value=0, frame_valid=0, frame_err=0, digit_mask=0.
  - Also clears: internal digit registers, bad-digit mask, run counter, sample register; FSM goes to IDLE.
  - Reset mid-frame discards all partial digits.
- Input stage: pins are registered each edge into s_reg.
  - "Match" = current pins equal s_reg and the pins' an_in is exactly one-hot.
- Run counter run (8 bit):
  - On match, increments, saturating at STABLE_CYCLES.
  - Otherwise loads 1 if the pins' an_in is one-hot, else 0.
- FSM states:
  - IDLE: no valid run. Go to COUNT when pins' an_in is one-hot.
  - COUNT: on match with run==STABLE_CYCLES-1, accept the digit at this edge and go to LOCKED. A mismatch restarts the run (stay in COUNT if one-hot, else IDLE).
  - LOCKED: no further accept until the sample changes. On a change, go to COUNT (one-hot) or IDLE (blank or multi-hot).
- Timing: a pattern held on the pins for edges k..k+STABLE_CYCLES-1 is accepted at edge k+STABLE_CYCLES-1.
- Accept for digit i:
  - Decode table (g..a hex): 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - Legal pattern: digit[i] = nibble, bad[i] = 0.
  - Illegal pattern (including 00, all segments off): digit[i] = 0, bad[i] = 1.
  - digit_mask[i] = 1 in both cases.
  - Re-accepting a digit already in the mask overwrites it; latest wins.
- Frame completion, on the edge after digit_mask becomes 4'hF:
  - value = {digit3, digit2, digit1, digit0}.
  - frame_err = OR of bad.
  - frame_valid = 1 for exactly that one cycle.
  - digit_mask and bad clear.
  - An accept on the same edge as completion belongs to the next frame: its mask bit is set after the clear.
- Blank or multi-hot an_in never accepts and never alters stored digits.
- value and frame_err hold between frames.

Test Plan:
- Reset, then drive an_in=0001/seg=06, 0010/5B, 0100/4F, 1000/66, each held 6 cycles -> one frame_valid pulse, value=16'h4321, frame_err=0, digit_mask returns to 0.
- Digit 0 pattern held only STABLE_CYCLES-1=3 cycles, then changed -> digit_mask[0] stays 0. Held exactly 4 cycles -> digit_mask[0] set on the 4th edge.
- Digit 2 driven with seg=7'h00, others legal (7F, 77, 5E) -> value[11:8]=0, frame_err=1.
- Pattern held 40 cycles on one digit -> exactly one accept. Toggle an_in to 0000 for 1 cycle, then same pattern again -> second accept, overwriting the first.
- an_in=0011 held 20 cycles -> no accept, digit_mask unchanged.
- rst asserted for 1 cycle after 3 digits are captured -> digit_mask=0, value and frame_err keep reset values 0. A full new frame then produces a correct value.
- SEG_ACTIVE_LOW=1 instance driven with inverted first-test stimulus -> value=16'h4321.

Source files
------------

// File: rtl/sev_seg_reader.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sev_seg_reader : samples a multiplexed 4-digit seven-segment bus, decodes
// stable digits and assembles them into 16-bit frames.          Rev 1.0
// -----------------------------------------------------------------------------
module sev_seg_reader #(
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] value,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [3:0]  digit_mask
);

   localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
   localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COUNT  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [10:0] s_reg;
   logic [7:0]  run;
   logic        one_hot;
   logic        match;
   logic        accept;
   logic        complete;
   logic [15:0] digits;
   logic [3:0]  bad;
   logic [3:0]  dec_nibble;
   logic        dec_legal;

   assign seg      = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
   assign an       = SEG_ACTIVE_LOW ? ~an_in  : an_in;
   assign one_hot  = (an != 4'h0) && ((an & (an - 4'h1)) == 4'h0);
   assign match    = one_hot && ({seg, an} == s_reg);
   assign complete = (digit_mask == 4'hF);

   always_comb begin
      dec_nibble = 4'h0;
      dec_legal  = 1'b1;
      case (seg)
         7'h3F:   dec_nibble = 4'h0;
         7'h06:   dec_nibble = 4'h1;
         7'h5B:   dec_nibble = 4'h2;
         7'h4F:   dec_nibble = 4'h3;
         7'h66:   dec_nibble = 4'h4;
         7'h6D:   dec_nibble = 4'h5;
         7'h7D:   dec_nibble = 4'h6;
         7'h07:   dec_nibble = 4'h7;
         7'h7F:   dec_nibble = 4'h8;
         7'h6F:   dec_nibble = 4'h9;
         7'h77:   dec_nibble = 4'hA;
         7'h7C:   dec_nibble = 4'hB;
         7'h39:   dec_nibble = 4'hC;
         7'h5E:   dec_nibble = 4'hD;
         7'h79:   dec_nibble = 4'hE;
         7'h71:   dec_nibble = 4'hF;
         default: dec_legal  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         s_reg <= 11'h0;
         run   <= 8'h0;
      end else begin
         state <= state_next;
         s_reg <= {seg, an};
         if (match) begin
            run <= (run == RUN_MAX) ? run : run + 8'd1;
         end else begin
            run <= one_hot ? 8'd1 : 8'd0;
         end
      end
   end

   // The digit is taken on the edge that completes STABLE_CYCLES identical samples.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (one_hot) state_next = COUNT;
         end
         COUNT: begin
            if (match) begin
               if (run == RUN_LAST) begin
                  accept     = 1'b1;
                  state_next = LOCKED;
               end
            end else begin
               state_next = one_hot ? COUNT : IDLE;
            end
         end
         LOCKED: begin
            if (!match) state_next = one_hot ? COUNT : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value       <= 16'h0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         digit_mask  <= 4'h0;
         digits      <= 16'h0;
         bad         <= 4'h0;
      end else begin
         frame_valid <= 1'b0;
         if (complete) begin
            value       <= digits;
            frame_err   <= |bad;
            frame_valid <= 1'b1;
         end
         // An accept coinciding with completion starts the next frame.
         for (int i = 0; i < 4; i++) begin
            if (accept && an[i]) begin
               digits[4*i +: 4] <= dec_legal ? dec_nibble : 4'h0;
               bad[i]           <= ~dec_legal;
               digit_mask[i]    <= 1'b1;
            end else if (complete) begin
               bad[i]        <= 1'b0;
               digit_mask[i] <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire
